sram_access_ctrl: RTL
=====================

Name: sram_access_ctrl

Overview:
- Memory-side sequencer between the CPU memory interface (ISDU/Mem2IO request side) and the external 1Mx16 SRAM tristate interface.
- Converts single-cycle read/write requests into timed SRAM cycles with configurable wait states.
- Drives the active-low SRAM strobes and latches read data.
- Returns a one-cycle ready pulse so the ISDU no longer needs hard-coded memory-wait states.

Parameters:
WAIT_CYCLES, 2, number of cycles the OE (read) or WE (write) strobe is held in ACCESS; a value of 0 is treated as 1
ADDR_W, 20, SRAM address width
DATA_W, 16, data word width

Ports:
Clk  in  1  system clock; all state updates on the rising edge
Reset  in  1  asynchronous, active-low reset
req_rd  in  1  read request, sampled in IDLE only
req_wr  in  1  write request, sampled in IDLE only
addr_in  in  ADDR_W  request address
wdata  in  DATA_W  write data
rdata  out  DATA_W  last read word, held until the next read completes
ready  out  1  one-cycle pulse marking access completion
busy  out  1  high in every state except IDLE
SRAM_ADDR  out  ADDR_W  registered address driven to the SRAM
sram_wdata  out  DATA_W  registered write data to the tristate buffer
sram_drive  out  1  tristate output enable (1 = FPGA drives Data)
sram_rdata  in  DATA_W  data read back from the tristate buffer
Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1 each  SRAM strobes, active low

Behaviour:
- Reset (async, Reset=0):
  - State = IDLE.
  - All Mem_* strobes = 1.
  - sram_drive = 0; ready = 0; busy = 0.
  - rdata, SRAM_ADDR and sram_wdata = 0.
  - Reset asserted mid-access aborts immediately; strobes release in the same cycle with no clock edge required.
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - If req_wr=1, latch addr_in and wdata, set op=WRITE, go to SETUP.
  - Else if req_rd=1, latch addr_in, set op=READ, go to SETUP.
  - If both are asserted, the write wins and the read is dropped (not queued).
- SETUP (1 cycle):
  - Mem_CE=0, Mem_UB=0, Mem_LB=0.
  - READ: Mem_OE=0.
  - WRITE: sram_drive=1, Mem_WE=1.
  - Wait counter loaded with max(WAIT_CYCLES,1)-1.
- ACCESS (max(WAIT_CYCLES,1) cycles):
  - READ: Mem_OE=0.
  - WRITE: Mem_WE=0 and sram_drive=1.
  - Counter decrements each cycle. At 0: on a READ, sram_rdata is captured into rdata; then go to DONE.
- DONE (1 cycle):
  - ready=1; Mem_WE=1; Mem_OE=1; Mem_CE=0.
  - WRITE only: sram_drive stays 1 for data hold.
  - Next state is IDLE; CE and drive release there.
- Latency: request sampled at edge N gives ready high during cycle N+max(WAIT_CYCLES,1)+2. With the default, the request edge is followed by SETUP, ACCESS, ACCESS, then DONE with ready.
- Requests asserted while busy=1 are ignored. A request held high through DONE is accepted again in IDLE, giving back-to-back accesses with one IDLE cycle between them.
- Mem_WE and Mem_OE are never low in the same cycle. sram_drive=1 never coincides with Mem_OE=0.
- SRAM_ADDR and sram_wdata change only on IDLE->SETUP.
- rdata is unchanged by writes.

Optional Feature:
- Macro: SRAM_ACCESS_COUNT_EN
- When defined:
  - Adds output access_count [15:0], reset to 0.
  - Increments once per DONE cycle for both reads and writes.
  - Saturates at 16'hFFFF with no wrap.
- When not defined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset then release; pulse req_rd with addr_in=20'h00012; sram_rdata model returns 16'hBEEF -> Mem_OE low for 3 cycles (SETUP + 2 ACCESS), ready pulses on the 4th cycle after the request edge, rdata=16'hBEEF, busy falls the following cycle.
- req_wr with addr_in=20'h0003F, wdata=16'h1234 -> SRAM_ADDR=20'h0003F, Mem_WE low for exactly 2 cycles, sram_drive high from SETUP through DONE, rdata unchanged, one ready pulse.
- req_rd and req_wr asserted together in IDLE -> exactly one write cycle, no OE assertion, a single ready pulse.
- Second req_rd pulsed while busy=1 -> ignored; exactly one ready; with SRAM_ACCESS_COUNT_EN, access_count increments by 1.
- Reset driven low during ACCESS of a write -> Mem_WE=1, Mem_CE=1 and sram_drive=0 before the next Clk edge; after release, state is IDLE and ready stays 0.
- WAIT_CYCLES=0 build; read of 20'h00001 -> one ACCESS cycle, ready on the 3rd cycle after the request edge.

Source files
------------

// File: rtl/sram_access_ctrl_if.sv
// CPU-side request/response bundle between the ISDU/Mem2IO logic and sram_access_ctrl.
// master = requester (CPU side), slave = the SRAM sequencer.
interface sram_access_ctrl_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);

  logic              req_rd;
  logic              req_wr;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              busy;

  modport master (
    output req_rd, req_wr, addr_in, wdata,
    input  rdata, ready, busy
  );

  modport slave (
    input  req_rd, req_wr, addr_in, wdata,
    output rdata, ready, busy
  );

endinterface

// File: rtl/sram_access_ctrl.sv
// SRAM access sequencer: turns single-cycle CPU requests into timed 1Mx16 SRAM cycles.
// Optional saturating access counter is enabled by defining SRAM_ACCESS_COUNT_EN.
module sram_access_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  sram_access_ctrl_if.slave cpu,
`ifdef SRAM_ACCESS_COUNT_EN
  output logic [15:0]       access_count,
`endif
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_drive,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              Mem_CE,
  output logic              Mem_UB,
  output logic              Mem_LB,
  output logic              Mem_OE,
  output logic              Mem_WE
);

  // A zero wait setting still needs one strobe cycle for the SRAM to respond.
  localparam int WAIT_EFF = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
  localparam int CNT_W    = (WAIT_EFF > 1) ? $clog2(WAIT_EFF) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_EFF - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_t;

  state_t            state;
  state_t            next_state;
  logic              op_wr;
  logic [CNT_W-1:0]  wait_cnt;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Request capture, wait counting and read-data latch.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      op_wr      <= 1'b0;
      SRAM_ADDR  <= '0;
      sram_wdata <= '0;
      wait_cnt   <= '0;
      cpu.rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu.req_wr) begin
            op_wr      <= 1'b1;
            SRAM_ADDR  <= cpu.addr_in;
            sram_wdata <= cpu.wdata;
          end else if (cpu.req_rd) begin
            op_wr     <= 1'b0;
            SRAM_ADDR <= cpu.addr_in;
          end
        end
        SETUP: begin
          wait_cnt <= CNT_LOAD;
        end
        ACCESS: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
          end else if (!op_wr) begin
            cpu.rdata <= sram_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef SRAM_ACCESS_COUNT_EN
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      access_count <= '0;
    end else if (state == DONE && access_count != 16'hFFFF) begin
      access_count <= access_count + 16'd1;
    end
  end
`endif

  // Strobes decode straight from state so an async reset releases them without a clock edge.
  always_comb begin
    next_state = state;
    Mem_CE     = 1'b1;
    Mem_UB     = 1'b1;
    Mem_LB     = 1'b1;
    Mem_OE     = 1'b1;
    Mem_WE     = 1'b1;
    sram_drive = 1'b0;
    cpu.ready  = 1'b0;
    cpu.busy   = (state != IDLE);

    case (state)
      IDLE: begin
        if (cpu.req_wr || cpu.req_rd) begin
          next_state = SETUP;
        end
      end
      SETUP: begin
        Mem_CE = 1'b0;
        Mem_UB = 1'b0;
        Mem_LB = 1'b0;
        if (op_wr) begin
          sram_drive = 1'b1;
        end else begin
          Mem_OE = 1'b0;
        end
        next_state = ACCESS;
      end
      ACCESS: begin
        Mem_CE = 1'b0;
        Mem_UB = 1'b0;
        Mem_LB = 1'b0;
        if (op_wr) begin
          Mem_WE     = 1'b0;
          sram_drive = 1'b1;
        end else begin
          Mem_OE = 1'b0;
        end
        if (wait_cnt == '0) begin
          next_state = DONE;
        end
      end
      DONE: begin
        Mem_CE     = 1'b0;
        Mem_UB     = 1'b0;
        Mem_LB     = 1'b0;
        sram_drive = op_wr;
        cpu.ready  = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule
